// File: rtl/resize_coord_sequencer_pkg.sv
// Shared types and constants for the resize coordinate sequencer.
//
// Contents:
//   FIX_W, FRAC_BITS, DIM_W - codebase-wide fixed-point and dimension widths
//   seq_states_t            - sequencer FSM state encoding
//   coef_rec_t              - record forwarded to the bilinear pixel-fetch stage
//   sfg_gen_in_t            - fields driven towards the scale-factor generator
//   sfg_gen_out_t           - fields returned by the scale-factor generator
//   clamp_limit()           - highest legal source coordinate for a dimension
package resize_coord_sequencer_pkg;

  localparam int FIX_W     = 32;
  localparam int FRAC_BITS = 18;
  localparam int DIM_W     = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_FDONE = 3'd4
  } seq_states_t;

  typedef struct packed {
    logic [DIM_W-1:0]     sx;
    logic [DIM_W-1:0]     sy;
    logic [FRAC_BITS-1:0] fx;
    logic [FRAC_BITS-1:0] fy;
    logic [DIM_W-1:0]     dx;
    logic [DIM_W-1:0]     dy;
    logic                 eol;
    logic                 eof;
  } coef_rec_t;

  typedef struct packed {
    logic             start;
    logic             taken;
    logic [FIX_W-1:0] factor_x;
    logic [FIX_W-1:0] factor_y;
    logic [FIX_W-1:0] dx;
    logic [FIX_W-1:0] dy;
  } sfg_gen_in_t;

  typedef struct packed {
    logic             ready;
    logic             done;
    logic [FIX_W-1:0] fx;
    logic [FIX_W-1:0] fy;
    logic [FIX_W-1:0] sx;
    logic [FIX_W-1:0] sy;
  } sfg_gen_out_t;

  // A zero-sized source dimension behaves like a one-pixel image.
  function automatic logic [DIM_W-1:0] clamp_limit(input logic [DIM_W-1:0] src_dim);
    return (src_dim == '0) ? '0 : src_dim - DIM_W'(1);
  endfunction

endpackage

// File: rtl/resize_coord_sequencer_coord_clamp.sv
// Combinational clamp of one generator coordinate/weight pair to the
// source image border. Used once for X and once for Y.
//
// Ports:
//   raw_coord [FIX_W]     integer source coordinate from the generator
//                         (two's complement wrap when negative)
//   raw_frac  [FRAC_BITS] fractional weight from the generator
//   src_dim   [DIM_W]     source dimension along this axis
//   coord     [DIM_W]     clamped coordinate
//   frac      [FRAC_BITS] clamped weight (0 whenever the coordinate is clamped)
module resize_coord_sequencer_coord_clamp
  import resize_coord_sequencer_pkg::*;
(
  input  logic [FIX_W-1:0]     raw_coord,
  input  logic [FRAC_BITS-1:0] raw_frac,
  input  logic [DIM_W-1:0]     src_dim,
  output logic [DIM_W-1:0]     coord,
  output logic [FRAC_BITS-1:0] frac
);

  logic [DIM_W-1:0] limit;
  logic             is_neg;
  logic             is_over;

  assign limit   = clamp_limit(src_dim);
  // The integer part occupies the upper FIX_W-FRAC_BITS bits of the
  // generator's fixed-point range; its top bit is the sign.
  assign is_neg  = raw_coord[FIX_W-FRAC_BITS-1];
  assign is_over = (raw_coord >= FIX_W'(limit));

  always_comb begin
    coord = raw_coord[DIM_W-1:0];
    frac  = raw_frac;
    if (is_neg) begin
      coord = '0;
      frac  = '0;
    end else if (is_over) begin
      coord = limit;
      frac  = '0;
    end
  end

endmodule

// File: rtl/resize_coord_sequencer.sv
// Frame-level initiator for the scale-factor generator of the resize
// pipeline. Walks every destination pixel in raster order (dx inner, dy
// outer), runs one start/done/taken transaction with the generator per
// pixel, clamps the returned source coordinates to the source border and
// forwards one record per pixel downstream.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   frame_start                  pulse: latch cfg_* and begin a frame (ignored while busy)
//   cfg_dst_w/h, cfg_src_w/h     destination size, source clamp bounds
//   cfg_factor_x/y               src/dst ratio, fixed point
//   sfg_start, sfg_taken         request / result-consumed strobes to the generator
//   sfg_factor_x/y, sfg_dx/dy    held factors and current destination pixel
//   sfg_ready, sfg_done          generator idle / result valid
//   sfg_fx/fy, sfg_sx/sy         generator result
//   coef_valid, coef_ready       downstream record handshake
//   coef_sx/sy/fx/fy/dx/dy       clamped record fields
//   coef_eol, coef_eof           record is last of row / last of frame
//   busy, frame_done             frame in progress / pulse after last record accepted
//   dbg_state                    current FSM state
//
// Handshakes: the generator samples a request when sfg_start && sfg_ready
// are both high at a clock edge; sfg_taken is high only in the cycle
// sfg_done is seen in S_WAIT, so start and taken are never high together.
// Downstream, a record transfers on a clock edge where coef_valid &&
// coef_ready; while coef_valid is high without coef_ready every coef_*
// output holds its value. Only one pixel is ever in flight.
module resize_coord_sequencer
  import resize_coord_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_start,
  input  logic [DIM_W-1:0]     cfg_dst_w,
  input  logic [DIM_W-1:0]     cfg_dst_h,
  input  logic [DIM_W-1:0]     cfg_src_w,
  input  logic [DIM_W-1:0]     cfg_src_h,
  input  logic [FIX_W-1:0]     cfg_factor_x,
  input  logic [FIX_W-1:0]     cfg_factor_y,
  output logic                 sfg_start,
  output logic                 sfg_taken,
  output logic [FIX_W-1:0]     sfg_factor_x,
  output logic [FIX_W-1:0]     sfg_factor_y,
  output logic [FIX_W-1:0]     sfg_dx,
  output logic [FIX_W-1:0]     sfg_dy,
  input  logic                 sfg_ready,
  input  logic                 sfg_done,
  input  logic [FIX_W-1:0]     sfg_fx,
  input  logic [FIX_W-1:0]     sfg_fy,
  input  logic [FIX_W-1:0]     sfg_sx,
  input  logic [FIX_W-1:0]     sfg_sy,
  output logic                 coef_valid,
  input  logic                 coef_ready,
  output logic [DIM_W-1:0]     coef_sx,
  output logic [DIM_W-1:0]     coef_sy,
  output logic [FRAC_BITS-1:0] coef_fx,
  output logic [FRAC_BITS-1:0] coef_fy,
  output logic [DIM_W-1:0]     coef_dx,
  output logic [DIM_W-1:0]     coef_dy,
  output logic                 coef_eol,
  output logic                 coef_eof,
  output logic                 busy,
  output logic                 frame_done,
  output seq_states_t          dbg_state
);

  seq_states_t state, state_nxt;

  // Frame configuration, frozen at frame_start.
  logic [DIM_W-1:0] dst_w_q, dst_h_q, src_w_q, src_h_q;
  logic [FIX_W-1:0] factor_x_q, factor_y_q;

  logic [DIM_W-1:0] dx_q, dy_q;
  coef_rec_t        rec_q;

  sfg_gen_out_t     sfg_rsp;
  sfg_gen_in_t      sfg_req;

  logic [DIM_W-1:0]     clamp_sx, clamp_sy;
  logic [FRAC_BITS-1:0] clamp_fx, clamp_fy;

  logic cfg_empty;
  logic launch;
  logic capture;
  logic accept;
  logic eol_now;
  logic eof_now;
  logic unused_frac_hi;

  assign sfg_rsp = '{ready: sfg_ready, done: sfg_done,
                     fx: sfg_fx, fy: sfg_fy, sx: sfg_sx, sy: sfg_sy};

  assign cfg_empty = (cfg_dst_w == '0) || (cfg_dst_h == '0);
  assign launch    = (state == S_IDLE) && frame_start;
  assign capture   = (state == S_WAIT) && sfg_rsp.done;
  assign accept    = (state == S_OUT) && coef_ready;
  assign eol_now   = (dx_q == dst_w_q - DIM_W'(1));
  assign eof_now   = eol_now && (dy_q == dst_h_q - DIM_W'(1));

  // Only the FRAC_BITS low bits of the weights carry information.
  assign unused_frac_hi = ^{sfg_rsp.fx[FIX_W-1:FRAC_BITS], sfg_rsp.fy[FIX_W-1:FRAC_BITS]};

  resize_coord_sequencer_coord_clamp u_clamp_x (
    .raw_coord (sfg_rsp.sx),
    .raw_frac  (sfg_rsp.fx[FRAC_BITS-1:0]),
    .src_dim   (src_w_q),
    .coord     (clamp_sx),
    .frac      (clamp_fx)
  );

  resize_coord_sequencer_coord_clamp u_clamp_y (
    .raw_coord (sfg_rsp.sy),
    .raw_frac  (sfg_rsp.fy[FRAC_BITS-1:0]),
    .src_dim   (src_h_q),
    .coord     (clamp_sy),
    .frac      (clamp_fy)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt = cfg_empty ? S_FDONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sfg_rsp.ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sfg_rsp.done) begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (coef_ready) begin
          state_nxt = rec_q.eof ? S_FDONE : S_ISSUE;
        end
      end
      S_FDONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dst_w_q    <= '0;
      dst_h_q    <= '0;
      src_w_q    <= '0;
      src_h_q    <= '0;
      factor_x_q <= '0;
      factor_y_q <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      rec_q      <= '0;
    end else begin
      if (launch) begin
        dst_w_q    <= cfg_dst_w;
        dst_h_q    <= cfg_dst_h;
        src_w_q    <= cfg_src_w;
        src_h_q    <= cfg_src_h;
        factor_x_q <= cfg_factor_x;
        factor_y_q <= cfg_factor_y;
        dx_q       <= '0;
        dy_q       <= '0;
      end
      if (capture) begin
        rec_q <= '{sx: clamp_sx, sy: clamp_sy, fx: clamp_fx, fy: clamp_fy,
                   dx: dx_q, dy: dy_q, eol: eol_now, eof: eof_now};
      end
      // dx/dy are unchanged between capture and accept, so the captured
      // eol flag is the row-wrap condition.
      if (accept) begin
        if (rec_q.eol) begin
          dx_q <= '0;
          dy_q <= dy_q + DIM_W'(1);
        end else begin
          dx_q <= dx_q + DIM_W'(1);
        end
      end
    end
  end

  // Strobes are gated by resetn so a reset cycle never issues a request
  // or acknowledges a result.
  always_comb begin
    sfg_req          = '0;
    sfg_req.start    = resetn && (state == S_ISSUE) && sfg_rsp.ready;
    sfg_req.taken    = resetn && capture;
    sfg_req.factor_x = factor_x_q;
    sfg_req.factor_y = factor_y_q;
    sfg_req.dx       = FIX_W'(dx_q);
    sfg_req.dy       = FIX_W'(dy_q);
  end

  assign sfg_start    = sfg_req.start;
  assign sfg_taken    = sfg_req.taken;
  assign sfg_factor_x = sfg_req.factor_x;
  assign sfg_factor_y = sfg_req.factor_y;
  assign sfg_dx       = sfg_req.dx;
  assign sfg_dy       = sfg_req.dy;

  assign coef_valid = (state == S_OUT);
  assign coef_sx    = rec_q.sx;
  assign coef_sy    = rec_q.sy;
  assign coef_fx    = rec_q.fx;
  assign coef_fy    = rec_q.fy;
  assign coef_dx    = rec_q.dx;
  assign coef_dy    = rec_q.dy;
  assign coef_eol   = rec_q.eol;
  assign coef_eof   = rec_q.eof;

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_FDONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_resize_coord_sequencer.sv
// Self-checking bench for resize_coord_sequencer. The bench plays the
// scale-factor generator, returning hand-computed raw results from a
// vector table, and compares every forwarded record against the
// hand-clamped values held in an expected queue.
module tb_resize_coord_sequencer;
  import resize_coord_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                 frame_start = 1'b0;
  logic [DIM_W-1:0]     cfg_dst_w = '0, cfg_dst_h = '0, cfg_src_w = '0, cfg_src_h = '0;
  logic [FIX_W-1:0]     cfg_factor_x = '0, cfg_factor_y = '0;
  logic                 sfg_start, sfg_taken;
  logic [FIX_W-1:0]     sfg_factor_x, sfg_factor_y, sfg_dx, sfg_dy;
  logic                 sfg_ready = 1'b1, sfg_done = 1'b0;
  logic [FIX_W-1:0]     sfg_fx = '0, sfg_fy = '0, sfg_sx = '0, sfg_sy = '0;
  logic                 coef_valid;
  logic                 coef_ready = 1'b0;
  logic [DIM_W-1:0]     coef_sx, coef_sy, coef_dx, coef_dy;
  logic [FRAC_BITS-1:0] coef_fx, coef_fy;
  logic                 coef_eol, coef_eof, busy, frame_done;
  seq_states_t          dbg_state;

  resize_coord_sequencer dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start),
    .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
    .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
    .cfg_factor_x(cfg_factor_x), .cfg_factor_y(cfg_factor_y),
    .sfg_start(sfg_start), .sfg_taken(sfg_taken),
    .sfg_factor_x(sfg_factor_x), .sfg_factor_y(sfg_factor_y),
    .sfg_dx(sfg_dx), .sfg_dy(sfg_dy),
    .sfg_ready(sfg_ready), .sfg_done(sfg_done),
    .sfg_fx(sfg_fx), .sfg_fy(sfg_fy), .sfg_sx(sfg_sx), .sfg_sy(sfg_sy),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_sx(coef_sx), .coef_sy(coef_sy), .coef_fx(coef_fx), .coef_fy(coef_fy),
    .coef_dx(coef_dx), .coef_dy(coef_dy), .coef_eol(coef_eol), .coef_eof(coef_eof),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  localparam int REC_W = 2 * DIM_W + 2 * FRAC_BITS + 2 * DIM_W + 2;

  wire [REC_W-1:0] coef_bus = {coef_sx, coef_sy, coef_fx, coef_fy, coef_dx, coef_dy, coef_eol, coef_eof};
  wire any_out = |{sfg_start, sfg_taken, sfg_factor_x, sfg_factor_y, sfg_dx, sfg_dy,
                   coef_valid, coef_bus, busy, frame_done};

  // ---------------- vector table ----------------
  typedef struct {
    logic [FIX_W-1:0]     raw_sx, raw_fx, raw_sy, raw_fy;
    logic [DIM_W-1:0]     sx;
    logic [FRAC_BITS-1:0] fx;
    logic [DIM_W-1:0]     sy;
    logic [FRAC_BITS-1:0] fy;
    logic [DIM_W-1:0]     dx, dy;
    logic                 eol, eof;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic [31:0] rsx, rfx, rsy, rfy,
                              input logic [11:0] sx, input logic [17:0] fx,
                              input logic [11:0] sy, input logic [17:0] fy,
                              input logic [11:0] dx, dy, input logic eol, eof);
    vec_t v;
    v.raw_sx = rsx; v.raw_fx = rfx; v.raw_sy = rsy; v.raw_fy = rfy;
    v.sx = sx; v.fx = fx; v.sy = sy; v.fy = fy;
    v.dx = dx; v.dy = dy; v.eol = eol; v.eof = eof;
    return v;
  endfunction

  function automatic logic [REC_W-1:0] pack_rec(input vec_t v);
    return {v.sx, v.sy, v.fx, v.fy, v.dx, v.dy, v.eol, v.eof};
  endfunction

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0, taken_cnt = 0, done_cnt = 0;
  logic [FIX_W-1:0] cur_fx, cur_fy;

  always @(posedge clk) begin
    if (sfg_start && sfg_ready) start_cnt <= start_cnt + 1;
    if (sfg_taken) taken_cnt <= taken_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [11:0] dw, dh, sw, sh, input logic [31:0] fx, fy);
    cfg_dst_w = dw; cfg_dst_h = dh; cfg_src_w = sw; cfg_src_h = sh;
    cfg_factor_x = fx; cfg_factor_y = fy;
    cur_fx = fx; cur_fy = fy;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    // Configuration must be latched; scramble it for the rest of the frame.
    cfg_dst_w = 12'($urandom_range(1, 3)); cfg_dst_h = 12'($urandom_range(1, 3));
    cfg_src_w = 12'($urandom_range(0, 50)); cfg_src_h = 12'($urandom_range(0, 50));
    cfg_factor_x = $urandom; cfg_factor_y = $urandom;
  endtask

  // Bounded wait for a request; returns with the bench at a falling edge.
  task automatic wait_start(input string tag);
    int cyc = 0;
    @(negedge clk);
    while (!sfg_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_start_seen"}, sfg_start, 1);
  endtask

  // One full pixel transaction, entered just after a rising edge with the
  // DUT in S_ISSUE.
  task automatic do_pixel(input int row, input int lat, input int stall, input int rdy_dly);
    logic [REC_W-1:0] exp_rec;
    string tag;
    tag = $sformatf("row%0d", row);
    sfg_ready = 1'b0;
    for (int k = 0; k < rdy_dly; k++) begin
      @(negedge clk);
      check({tag, "_no_start_unready"}, sfg_start, 0);
      tick();
    end
    sfg_ready = 1'b1;
    wait_start(tag);
    check({tag, "_sfg_dx"}, sfg_dx, {20'h0, tbl[row].dx});
    check({tag, "_sfg_dy"}, sfg_dy, {20'h0, tbl[row].dy});
    check({tag, "_factors"}, {sfg_factor_x, sfg_factor_y}, {cur_fx, cur_fy});
    tick();
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_wait_quiet"}, {sfg_start, sfg_taken, coef_valid}, 3'b000);
      tick();
    end
    sfg_done = 1'b1;
    sfg_sx = tbl[row].raw_sx; sfg_fx = tbl[row].raw_fx;
    sfg_sy = tbl[row].raw_sy; sfg_fy = tbl[row].raw_fy;
    @(negedge clk);
    check({tag, "_taken"}, {sfg_taken, sfg_start}, 2'b10);
    tick();
    sfg_done = 1'b0;
    sfg_sx = $urandom; sfg_fx = $urandom; sfg_sy = $urandom; sfg_fy = $urandom;
    exp_rec = exp_q.pop_front();
    @(negedge clk);
    check({tag, "_valid"}, coef_valid, 1);
    check({tag, "_record"}, coef_bus, exp_rec);
    for (int k = 0; k < stall; k++) begin
      // Spurious done pulses and a frame_start while busy must be ignored.
      sfg_done = k[0];
      frame_start = (k == 3);
      tick();
      @(negedge clk);
      check({tag, "_stall_hold"}, {coef_valid, coef_bus}, {1'b1, exp_rec});
      check({tag, "_stall_quiet"}, {sfg_start, sfg_taken}, 2'b00);
    end
    sfg_done = 1'b0;
    frame_start = 1'b0;
    coef_ready = 1'b1;
    tick();
    coef_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] dw, dh, sw, sh, input logic [31:0] fx, fy,
                           input int first, input int n, input int stall_row);
    int s0, t0, d0;
    s0 = start_cnt; t0 = taken_cnt; d0 = done_cnt;
    for (int i = first; i < first + n; i++) exp_q.push_back(pack_rec(tbl[i]));
    pulse_start(dw, dh, sw, sh, fx, fy);
    for (int i = first; i < first + n; i++) begin
      do_pixel(i, i % 3, (i == stall_row) ? 10 : 0, (i % 4 == 1) ? 2 : 0);
    end
    @(negedge clk);
    check("frame_done_pulse", {frame_done, busy}, 2'b11);
    tick();
    @(negedge clk);
    check("frame_done_end", {frame_done, busy}, 2'b00);
    check("start_count", start_cnt - s0, n);
    check("taken_count", taken_cnt - t0, n);
    check("done_count", done_cnt - d0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Frame A: factor 2.0, dst 2x1, src 8x8.
    tbl[0]  = mk(32'd0, 32'h20000, 32'd0, 32'h20000, 12'd0, 18'h20000, 12'd0, 18'h20000, 12'd0, 12'd0, 1'b0, 1'b0);
    tbl[1]  = mk(32'd2, 32'h20000, 32'd0, 32'h20000, 12'd2, 18'h20000, 12'd0, 18'h20000, 12'd1, 12'd0, 1'b1, 1'b1);
    // Frame B: factor_x 4.0, factor_y 0.5, dst 4x2, src 4x4.
    // Row 0 of Y wraps negative (clamp low); X beyond dx=0 clamps high to 3.
    tbl[2]  = mk(32'd1,  32'hABC20000, 32'hFFFFFFFF, 32'h30000, 12'd1, 18'h20000, 12'd0, 18'h0, 12'd0, 12'd0, 1'b0, 1'b0);
    tbl[3]  = mk(32'd5,  32'h20000,    32'hFFFFFFFF, 32'h30000, 12'd3, 18'h0,     12'd0, 18'h0, 12'd1, 12'd0, 1'b0, 1'b0);
    tbl[4]  = mk(32'd9,  32'h20000,    32'hFFFFFFFF, 32'h30000, 12'd3, 18'h0,     12'd0, 18'h0, 12'd2, 12'd0, 1'b0, 1'b0);
    tbl[5]  = mk(32'd13, 32'h20000,    32'hFFFFFFFF, 32'h30000, 12'd3, 18'h0,     12'd0, 18'h0, 12'd3, 12'd0, 1'b1, 1'b0);
    tbl[6]  = mk(32'd1,  32'h20000, 32'd0, 32'h10000, 12'd1, 18'h20000, 12'd0, 18'h10000, 12'd0, 12'd1, 1'b0, 1'b0);
    tbl[7]  = mk(32'd5,  32'h20000, 32'd0, 32'h10000, 12'd3, 18'h0,     12'd0, 18'h10000, 12'd1, 12'd1, 1'b0, 1'b0);
    tbl[8]  = mk(32'd9,  32'h20000, 32'd0, 32'h10000, 12'd3, 18'h0,     12'd0, 18'h10000, 12'd2, 12'd1, 1'b0, 1'b0);
    tbl[9]  = mk(32'd13, 32'h20000, 32'd0, 32'h10000, 12'd3, 18'h0,     12'd0, 18'h10000, 12'd3, 12'd1, 1'b1, 1'b1);
    // Frame C: src 0x0 acts as 1x1, so everything clamps to 0 with zero weight.
    tbl[10] = mk(32'd0, 32'h12345, 32'd2, 32'h1, 12'd0, 18'h0, 12'd0, 18'h0, 12'd0, 12'd0, 1'b1, 1'b1);

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs_zero", any_out, 0);
    check("reset_state", dbg_state, S_IDLE);
    resetn = 1'b1;
    tick();

    run_frame(12'd2, 12'd1, 12'd8, 12'd8, 32'h80000, 32'h80000, 0, 2, -1);
    run_frame(12'd4, 12'd2, 12'd4, 12'd4, 32'h100000, 32'h20000, 2, 8, 4);
    run_frame(12'd1, 12'd1, 12'd0, 12'd0, 32'h40000, 32'h40000, 10, 1, -1);

    // Empty frames: frame_start is sampled at one edge, frame_done is high
    // in the following cycle, and no request is ever issued.
    for (int e = 0; e < 2; e++) begin
      int s0;
      s0 = start_cnt;
      pulse_start((e == 0) ? 12'd0 : 12'd5, (e == 0) ? 12'd5 : 12'd0, 12'd8, 12'd8, 32'h80000, 32'h80000);
      @(negedge clk);
      check("empty_frame_done", {frame_done, busy}, 2'b11);
      tick();
      @(negedge clk);
      check("empty_frame_idle", {frame_done, busy}, 2'b00);
      repeat (3) tick();
      check("empty_no_start", start_cnt - s0, 0);
    end

    // Reset while waiting on the generator aborts without a taken.
    begin
      int t0;
      t0 = taken_cnt;
      pulse_start(12'd2, 12'd1, 12'd8, 12'd8, 32'h80000, 32'h80000);
      wait_start("rst");
      tick();
      @(negedge clk);
      check("rst_in_wait", dbg_state, S_WAIT);
      resetn = 1'b0;
      sfg_done = 1'b1;
      sfg_sx = 32'd2; sfg_fx = 32'h20000;
      @(negedge clk);
      check("rst_no_taken", sfg_taken, 0);
      tick();
      sfg_done = 1'b0;
      @(negedge clk);
      check("rst_outputs_zero", any_out, 0);
      check("rst_taken_count", taken_cnt - t0, 0);
      resetn = 1'b1;
      tick();
    end
    run_frame(12'd2, 12'd1, 12'd8, 12'd8, 32'h80000, 32'h80000, 0, 2, -1);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
